// File: rtl/matrix_scan_driver_if.sv
// rtl/matrix_scan_driver_if.sv - frame-store read port and LED panel signal bundle
//
// Purpose: groups the frame-store read port (read_addr/pixel_data) and the LED
//   panel drive lines of matrix_scan_driver into one interface.
// Optional: MATRIX_SCAN_TEST_PATTERN_EN adds the test_mode input.
// Signals:
//   read_addr   driver -> store  pixel address being fetched
//   pixel_data  store  -> driver RGB332 pixel at read_addr, same cycle
//   test_mode   tb/sys -> driver (optional) sample read_addr as the pixel
//   r/g/b_sdo   driver -> panel  serial column data
//   sclk        driver -> panel  shift clock, data stable on its rising edge
//   latch       driver -> panel  1-clk transfer pulse
//   oe_n        driver -> panel  column output enable, active-low
//   row_addr    driver -> panel  binary row currently displayed
//   frame_start driver -> system 1-clk pulse at row 0 / slot 0 shift start
interface matrix_scan_driver_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int COLOR_DEPTH = 8,
  parameter int ROW_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0]  read_addr;
  logic [COLOR_DEPTH-1:0] pixel_data;
  logic                   r_sdo;
  logic                   g_sdo;
  logic                   b_sdo;
  logic                   sclk;
  logic                   latch;
  logic                   oe_n;
  logic [ROW_WIDTH-1:0]   row_addr;
  logic                   frame_start;
`ifdef MATRIX_SCAN_TEST_PATTERN_EN
  logic                   test_mode;
`endif

  modport master (
    input  pixel_data,
`ifdef MATRIX_SCAN_TEST_PATTERN_EN
    input  test_mode,
`endif
    output read_addr,
    output r_sdo,
    output g_sdo,
    output b_sdo,
    output sclk,
    output latch,
    output oe_n,
    output row_addr,
    output frame_start
  );

  modport slave (
    output pixel_data,
`ifdef MATRIX_SCAN_TEST_PATTERN_EN
    output test_mode,
`endif
    input  read_addr,
    input  r_sdo,
    input  g_sdo,
    input  b_sdo,
    input  sclk,
    input  latch,
    input  oe_n,
    input  row_addr,
    input  frame_start
  );
endinterface

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - 1/16-duty LED matrix scanner with 7-slot PWM
//
// Purpose: reads RGB332 pixels from a combinational frame store and scans a
//   MATRIX_SIZE x MATRIX_SIZE LED matrix one row at a time. Each row is shown
//   for 7 PWM slots; per slot the row's columns are shifted out (col 15 first)
//   on three serial lines, latched, then displayed for ON_CYCLES clocks.
// Optional: MATRIX_SCAN_TEST_PATTERN_EN adds bus.test_mode; when 1 the sampled
//   pixel is read_addr itself instead of pixel_data.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active-low
//   bus    matrix_scan_driver_if.master: read_addr/pixel_data store port,
//          r/g/b_sdo, sclk, latch, oe_n, row_addr, frame_start panel outputs
module matrix_scan_driver #(
  parameter int MATRIX_SIZE = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int COLOR_DEPTH = 8,
  parameter int SCLK_DIV    = 1,
  parameter int ON_CYCLES   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_scan_driver_if.master bus
);
  localparam int COL_W = $clog2(MATRIX_SIZE);
  localparam int ROW_W = COL_W;
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int ON_W  = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(MATRIX_SIZE - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [ON_W-1:0]  ON_LAST   = ON_W'(ON_CYCLES - 1);
  localparam logic [2:0]       LAST_SLOT = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t                  state;
  logic                    idle_armed;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        shift_row;
  logic [2:0]              slot;
  logic [DIV_W-1:0]        div_cnt;
  logic                    high_phase;
  logic [ON_W-1:0]         on_cnt;

  logic [ADDR_WIDTH-1:0]   read_addr_q;
  logic [2:0]              rgb_q;
  logic                    sclk_q;
  logic                    latch_q;
  logic                    oe_n_q;
  logic [ROW_W-1:0]        row_addr_q;
  logic                    frame_start_q;

  logic [COLOR_DEPTH-1:0]  sample_pix;
  logic                    slot_wrap;
  logic [2:0]              nxt_slot;
  logic [ROW_W-1:0]        nxt_row;

`ifdef MATRIX_SCAN_TEST_PATTERN_EN
  assign sample_pix = bus.test_mode ? COLOR_DEPTH'(read_addr_q) : bus.pixel_data;
`else
  assign sample_pix = bus.pixel_data;
`endif

  // Row/slot that the next SHIFT phase will use.
  assign slot_wrap = (slot == LAST_SLOT);
  assign nxt_slot  = slot_wrap ? 3'd0 : slot + 3'd1;
  assign nxt_row   = slot_wrap ? shift_row + ROW_W'(1) : shift_row;

  // PWM compare; blue is widened to 3 bits by repeating its MSB.
  function automatic logic [2:0] pwm_bits(input logic [COLOR_DEPTH-1:0] pix,
                                          input logic [2:0] p);
    logic [2:0] b3;
    b3 = {pix[1], pix[0], pix[1]};
    return {pix[7:5] > p, pix[4:2] > p, b3 > p};
  endfunction

  // read_addr runs one column ahead: the pixel for column c is presented in
  // the cycle before column c's low phase, so sdo is registered on the same
  // edge that drops sclk and has a full low phase of setup before it rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idle_armed    <= 1'b0;
      col           <= LAST_COL;
      shift_row     <= '0;
      slot          <= 3'd0;
      div_cnt       <= '0;
      high_phase    <= 1'b0;
      on_cnt        <= '0;
      read_addr_q   <= '0;
      rgb_q         <= 3'b000;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      row_addr_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      latch_q       <= 1'b0;
      frame_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          oe_n_q <= 1'b1;
          if (!idle_armed) begin
            idle_armed  <= 1'b1;
            read_addr_q <= {shift_row, LAST_COL};
          end else begin
            state         <= S_SHIFT;
            col           <= LAST_COL;
            div_cnt       <= '0;
            high_phase    <= 1'b0;
            sclk_q        <= 1'b0;
            rgb_q         <= pwm_bits(sample_pix, slot);
            read_addr_q   <= {shift_row, LAST_COL - COL_W'(1)};
            frame_start_q <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!high_phase) begin
              high_phase <= 1'b1;
              sclk_q     <= 1'b1;
            end else if (col == '0) begin
              high_phase <= 1'b0;
              sclk_q     <= 1'b0;
              state      <= S_LATCH;
              latch_q    <= 1'b1;
              row_addr_q <= shift_row;
            end else begin
              col         <= col - COL_W'(1);
              high_phase  <= 1'b0;
              sclk_q      <= 1'b0;
              rgb_q       <= pwm_bits(sample_pix, slot);
              read_addr_q <= {shift_row, col - COL_W'(2)};
            end
          end
        end

        S_LATCH: begin
          state       <= S_DISPLAY;
          oe_n_q      <= 1'b0;
          on_cnt      <= '0;
          read_addr_q <= {nxt_row, LAST_COL};
        end

        S_DISPLAY: begin
          if (on_cnt == ON_LAST) begin
            oe_n_q        <= 1'b1;
            slot          <= nxt_slot;
            shift_row     <= nxt_row;
            state         <= S_SHIFT;
            col           <= LAST_COL;
            div_cnt       <= '0;
            high_phase    <= 1'b0;
            rgb_q         <= pwm_bits(sample_pix, nxt_slot);
            read_addr_q   <= {nxt_row, LAST_COL - COL_W'(1)};
            frame_start_q <= (nxt_slot == 3'd0) && (nxt_row == '0);
          end else begin
            on_cnt <= on_cnt + ON_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.read_addr   = read_addr_q;
  assign bus.r_sdo       = rgb_q[2];
  assign bus.g_sdo       = rgb_q[1];
  assign bus.b_sdo       = rgb_q[0];
  assign bus.sclk        = sclk_q;
  assign bus.latch       = latch_q;
  assign bus.oe_n        = oe_n_q;
  assign bus.row_addr    = row_addr_q;
  assign bus.frame_start = frame_start_q;
endmodule
